vmem_width_bridge: RTL and testbench

- Sits directly downstream of the vector core's memory port.
- Accepts one VMEM_W-wide request at a time on the vector req/gnt/rvalid interface.
- Splits it into VMEM_W/DMEM_W in-order sub-beats on a narrower DMEM_W data-cache port.
- Reassembles the sub-beat responses into a single VMEM_W-wide response with a merged error flag.

---
 rtl/vmem_width_bridge_if.sv | 25 ++
 rtl/vmem_width_bridge.sv | 131 +++++++++++++
 tb/tb_vmem_width_bridge.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmem_width_bridge_if.sv
// Request/grant/rvalid memory bus shared by the vector side and the data-cache side.
// The master drives requests, and the slave answers with grants and responses.
interface vmem_width_bridge_if #(
    parameter int DATA_W = 128
);
    logic                  req;
    logic                  gnt;
    logic [31:0]           addr;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/vmem_width_bridge.sv
// Splits one wide vector memory request into VMEM_W/DMEM_W in-order cache sub-beats.
// It reassembles the sub-beat responses into one wide response with a merged error flag.
module vmem_width_bridge #(
    parameter int VMEM_W = 128,
    parameter int DMEM_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    vmem_width_bridge_if.slave  vmem,
    vmem_width_bridge_if.master dmem
);
    localparam int N      = VMEM_W / DMEM_W;
    localparam int CW     = (N > 1) ? $clog2(N) : 1;
    localparam int VBE    = VMEM_W / 8;
    localparam int DBE    = DMEM_W / 8;
    localparam int OFF_W  = $clog2(VBE);
    localparam int DOFF_W = $clog2(DBE);
    localparam logic [CW-1:0] LAST      = CW'(N - 1);
    localparam logic [31:0]   ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       ic_q, rc_q;
    logic                err_q;
    logic [31:0]         addr_q;
    logic                we_q;
    logic [VBE-1:0]      be_q;
    logic [VMEM_W-1:0]   wdata_q;
    logic [VMEM_W-1:0]   rdata_q;
    logic [VMEM_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    logic                vmem_gnt;
    logic                dmem_req;
    logic                rsp_valid;
    logic                issue_hs;
    logic                rsp_hs;
    logic [VMEM_W-1:0]   rdata_merged;

    always_comb begin
        state_d   = state_q;
        vmem_gnt  = 1'b0;
        dmem_req  = 1'b0;
        rsp_valid = 1'b0;
        issue_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                // No acceptance is advertised in a cycle that is being reset away.
                vmem_gnt = vmem.req & rst_ni;
                if (vmem.req) state_d = ISSUE;
            end
            ISSUE: begin
                dmem_req = 1'b1;
                issue_hs = dmem.gnt;
                if (dmem.gnt && ic_q == LAST) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                state_d = WAIT_RSP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Responses are collected while sub-beats are still being issued.
        rsp_hs = dmem.rvalid && (state_q == ISSUE || state_q == WAIT_RSP);
        if (rsp_hs && rc_q == LAST) state_d = RESP;
    end

    always_comb begin
        rdata_merged = rdata_q;
        rdata_merged[rc_q*DMEM_W +: DMEM_W] = dmem.rdata;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ic_q       <= '0;
            rc_q       <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && vmem.req) begin
                addr_q  <= vmem.addr & ADDR_MASK;
                we_q    <= vmem.we;
                be_q    <= vmem.be;
                wdata_q <= vmem.wdata;
                ic_q    <= '0;
                rc_q    <= '0;
                err_q   <= 1'b0;
            end
            if (issue_hs) ic_q <= ic_q + 1'b1;
            if (rsp_hs) begin
                rdata_q <= rdata_merged;
                err_q   <= err_q | dmem.err;
                rc_q    <= rc_q + 1'b1;
                // The presented response is held in its own registers so that it stays
                // stable while the next transaction is being collected.
                if (rc_q == LAST) begin
                    rsp_data_q <= rdata_merged;
                    rsp_err_q  <= err_q | dmem.err;
                end
            end
        end
    end

    assign vmem.gnt    = vmem_gnt;
    assign vmem.rvalid = rsp_valid;
    assign vmem.rdata  = rsp_data_q;
    assign vmem.err    = rsp_err_q;

    assign dmem.req    = dmem_req;
    assign dmem.addr   = addr_q + (32'(ic_q) << DOFF_W);
    assign dmem.we     = we_q;
    assign dmem.be     = be_q[ic_q*DBE +: DBE];
    assign dmem.wdata  = wdata_q[ic_q*DMEM_W +: DMEM_W];
endmodule

// File: tb/tb_vmem_width_bridge.sv
// Directed scoreboard bench for vmem_width_bridge with 128-bit vector and 64-bit cache sides.
module tb_vmem_width_bridge;
    localparam int VMEM_W = 128;
    localparam int DMEM_W = 64;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    vmem_width_bridge_if #(.DATA_W(VMEM_W)) vmem_if ();
    vmem_width_bridge_if #(.DATA_W(DMEM_W)) dmem_if ();

    vmem_width_bridge #(.VMEM_W(VMEM_W), .DMEM_W(DMEM_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .vmem   (vmem_if),
        .dmem   (dmem_if)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
    } sub_t;

    typedef struct {
        logic [127:0] rdata;
        logic         err;
        logic         is_store;
        int           exp_cyc;
    } rsp_t;

    sub_t sub_q[$];
    rsp_t rsp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int stall_cnt = 0;
    int stall_lim = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cache-side slave: stalls grants on request, answers each grant one cycle later.
    assign dmem_if.gnt = !(stall_cnt < stall_lim && dmem_if.req === 1'b1 && dmem_if.addr == stall_addr);

    initial begin
        bit hs;
        bit stalled;
        logic [31:0] a;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = '0;
        dmem_if.err    = 1'b0;
        forever begin
            @(negedge clk);
            hs      = (dmem_if.req === 1'b1) && (dmem_if.gnt === 1'b1);
            stalled = (dmem_if.req === 1'b1) && (dmem_if.gnt === 1'b0);
            a       = dmem_if.addr;
            @(posedge clk);
            #1;
            dmem_if.rvalid = hs;
            dmem_if.rdata  = hs ? {32'hDA7A_0000, a} : 64'h0;
            dmem_if.err    = hs && (a == err_addr);
            if (stalled) stall_cnt++;
        end
    end

    // Monitor: sub-beat request fields on every requesting cycle, vector responses on rvalid.
    always @(negedge clk) begin
        sub_t s;
        rsp_t r;
        if (mon_en && dmem_if.req === 1'b1) begin
            chk(sub_q.size() > 0, "dmem_unexpected_req", 128'(dmem_if.addr), 128'(0));
            if (sub_q.size() > 0) begin
                s = sub_q[0];
                chk(dmem_if.addr == s.addr && dmem_if.we == s.we && dmem_if.be == s.be && dmem_if.wdata == s.wdata,
                    "dmem_req_fields",
                    128'({dmem_if.addr, 7'd0, dmem_if.we, dmem_if.be, dmem_if.wdata}),
                    128'({s.addr, 7'd0, s.we, s.be, s.wdata}));
                if (dmem_if.gnt === 1'b1) void'(sub_q.pop_front());
            end
        end
        if (mon_en && vmem_if.rvalid === 1'b1) begin
            chk(vmem_if.gnt === 1'b0, "vmem_gnt_during_resp", 128'(vmem_if.gnt), 128'(0));
            chk(rsp_q.size() > 0, "vmem_unexpected_rvalid", 128'(1), 128'(0));
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                chk(vmem_if.err === r.err, "vmem_err", 128'(vmem_if.err), 128'(r.err));
                if (!r.is_store)
                    chk(vmem_if.rdata === r.rdata, "vmem_rdata", vmem_if.rdata, r.rdata);
                if (r.exp_cyc >= 0)
                    chk(cyc == r.exp_cyc, "vmem_latency", 128'(cyc), 128'(r.exp_cyc));
            end
        end
    end

    task automatic push_sub(input logic [31:0] a, input logic we, input logic [7:0] be, input logic [63:0] w);
        sub_t s;
        s.addr = a; s.we = we; s.be = be; s.wdata = w;
        sub_q.push_back(s);
    endtask

    task automatic vmem_txn(input logic [31:0] addr, input logic we, input logic [15:0] be,
                            input logic [127:0] wdata,
                            input logic [31:0] a0, input logic [7:0] be0, input logic [63:0] w0,
                            input logic [31:0] a1, input logic [7:0] be1, input logic [63:0] w1,
                            input logic [127:0] exp_rdata, input logic exp_err, input int lat,
                            input bit hold);
        rsp_t r;
        int w;
        push_sub(a0, we, be0, w0);
        push_sub(a1, we, be1, w1);
        vmem_if.req   = 1'b1;
        vmem_if.addr  = addr;
        vmem_if.we    = we;
        vmem_if.be    = be;
        vmem_if.wdata = wdata;
        w = 0;
        @(negedge clk);
        while (vmem_if.gnt !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(w < 20, "vmem_gnt_timeout", 128'(w), 128'(20));
        r.rdata    = exp_rdata;
        r.err      = exp_err;
        r.is_store = we;
        r.exp_cyc  = (lat < 0) ? -1 : cyc + lat;
        rsp_q.push_back(r);
        @(posedge clk);
        #1;
        if (!hold) vmem_if.req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int w;
        w = 0;
        while ((rsp_q.size() != 0 || sub_q.size() != 0) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk(w < 40, {name, "_done_timeout"}, 128'(w), 128'(40));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        chk(vmem_if.gnt === 1'b0 && vmem_if.rvalid === 1'b0 && vmem_if.err === 1'b0 && dmem_if.req === 1'b0,
            {name, "_ctrl"}, 128'({vmem_if.gnt, vmem_if.rvalid, vmem_if.err, dmem_if.req}), 128'(0));
        chk(vmem_if.rdata === 128'h0, {name, "_rdata"}, vmem_if.rdata, 128'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vmem_if.req   = 1'b0;
        vmem_if.addr  = '0;
        vmem_if.we    = 1'b0;
        vmem_if.be    = '0;
        vmem_if.wdata = '0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        // Load at an unaligned-in-vector address, fully ready cache.
        vmem_txn(32'h0000_1008, 1'b0, 16'hFFFF, '0,
                 32'h0000_1000, 8'hFF, 64'h0, 32'h0000_1008, 8'hFF, 64'h0,
                 128'hDA7A0000_00001008_DA7A0000_00001000, 1'b0, 4, 1'b0);
        wait_done("load");

        // Store with sparse byte enables.
        vmem_txn(32'h0000_2000, 1'b1, 16'hF00F, 128'h11112222_33334444_55556666_77778888,
                 32'h0000_2000, 8'h0F, 64'h55556666_77778888,
                 32'h0000_2008, 8'hF0, 64'h11112222_33334444,
                 128'h0, 1'b0, 4, 1'b0);
        wait_done("store");

        // Grant withheld for three cycles on the second sub-beat.
        stall_addr = 32'h0000_3008;
        stall_lim  = stall_cnt + 3;
        vmem_txn(32'h0000_3000, 1'b0, 16'hFFFF, '0,
                 32'h0000_3000, 8'hFF, 64'h0, 32'h0000_3008, 8'hFF, 64'h0,
                 128'hDA7A0000_00003008_DA7A0000_00003000, 1'b0, 7, 1'b0);
        wait_done("stall");
        stall_addr = 32'hFFFF_FFFF;

        // Error on the first sub-beat only.
        err_addr = 32'h0000_4000;
        vmem_txn(32'h0000_4000, 1'b0, 16'hFFFF, '0,
                 32'h0000_4000, 8'hFF, 64'h0, 32'h0000_4008, 8'hFF, 64'h0,
                 128'hDA7A0000_00004008_DA7A0000_00004000, 1'b1, 4, 1'b0);
        wait_done("error");
        err_addr = 32'hFFFF_FFFF;

        // Back-to-back with the request held high.
        vmem_txn(32'h0000_5000, 1'b0, 16'hFFFF, '0,
                 32'h0000_5000, 8'hFF, 64'h0, 32'h0000_5008, 8'hFF, 64'h0,
                 128'hDA7A0000_00005008_DA7A0000_00005000, 1'b0, 4, 1'b1);
        vmem_txn(32'h0000_6018, 1'b0, 16'hFFFF, '0,
                 32'h0000_6010, 8'hFF, 64'h0, 32'h0000_6018, 8'hFF, 64'h0,
                 128'hDA7A0000_00006018_DA7A0000_00006010, 1'b0, 4, 1'b0);
        wait_done("b2b");

        // Reset for one cycle right after the first sub-beat grant.
        push_sub(32'h0000_7000, 1'b0, 8'hFF, 64'h0);
        push_sub(32'h0000_7008, 1'b0, 8'hFF, 64'h0);
        vmem_if.req   = 1'b1;
        vmem_if.addr  = 32'h0000_7000;
        vmem_if.we    = 1'b0;
        vmem_if.be    = 16'hFFFF;
        vmem_if.wdata = '0;
        w = 0;
        @(negedge clk);
        while (vmem_if.gnt !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(w < 20, "midrst_gnt_timeout", 128'(w), 128'(20));
        @(posedge clk);
        #1 vmem_if.req = 1'b0;
        w = 0;
        @(negedge clk);
        while (!(dmem_if.req === 1'b1 && dmem_if.gnt === 1'b1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(w < 20, "midrst_dmem_gnt_timeout", 128'(w), 128'(20));
        @(posedge clk);
        #1 rst_ni = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        repeat (4) @(negedge clk);
        wait_done("midrst");

        // Normal load after the abandoned transaction.
        vmem_txn(32'h0000_7000, 1'b0, 16'hFFFF, '0,
                 32'h0000_7000, 8'hFF, 64'h0, 32'h0000_7008, 8'hFF, 64'h0,
                 128'hDA7A0000_00007008_DA7A0000_00007000, 1'b0, 4, 1'b0);
        wait_done("post_rst");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
